router_fifo: RTL and testbench

- Output buffer for one router destination port; sits directly downstream of the router register stage.
- Stores header, payload and parity bytes driven on that stage's dout, tagging each entry with the lfd_state (header) flag.
- Read side is drained by the destination; tracks packet length from the header so the end of each packet is flagged.
- Supports soft reset from the router controller when a destination times out.

---
 rtl/router_fifo_pkg.sv | 20 ++
 rtl/router_fifo_mem.sv | 25 ++
 rtl/router_fifo.sv | 109 ++++++++++
 tb/tb_router_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/router_fifo_pkg.sv
// Shared router definitions: default data width, FIFO depth and header field layout.
package router_fifo_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH = 16;

  // Header byte: destination address in the low bits, payload length above it.
  localparam int unsigned HDR_ADDR_LSB = 0;
  localparam int unsigned HDR_ADDR_MSB = 1;
  localparam int unsigned HDR_LEN_LSB  = 2;
  localparam int unsigned HDR_LEN_MSB  = 7;
  localparam int unsigned HDR_LEN_W    = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  typedef logic [HDR_LEN_W-1:0] hdr_len_t;

  function automatic hdr_len_t hdr_len(input logic [DATA_WIDTH-1:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// DEPTH x (WIDTH+1) register array: one synchronous write port, one combinational read port, no reset.
module router_fifo_mem
  import router_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned WIDTH = DATA_WIDTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [WIDTH:0] wdata,
  input  logic [AW-1:0]  raddr,
  output logic [WIDTH:0] rdata
);

  logic [WIDTH:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/router_fifo.sv
// Per-destination router output FIFO with header tagging and end-of-packet detection.
// Optional almost_full output enabled by defining ROUTER_FIFO_ALMOST_FULL_EN.
module router_fifo
  import router_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = FIFO_DEPTH,
  parameter int unsigned WIDTH     = DATA_WIDTH,
  parameter int unsigned AF_THRESH = 14
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
`ifdef ROUTER_FIFO_ALMOST_FULL_EN
  output logic             almost_full,
`endif
  output logic             pkt_rd_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = WIDTH - 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             pkt_rd_done_q, pkt_rd_done_d;
  logic [WIDTH:0]   rd_word;
  logic             wr_go, rd_go;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Soft reset masks the memory write as well as the pointer updates.
  assign wr_go = write_enb && !full && !soft_reset;
  assign rd_go = read_enb && !empty && !soft_reset;

`ifdef ROUTER_FIFO_ALMOST_FULL_EN
  logic [AW:0] occupancy;
  assign occupancy   = wr_ptr_q - rd_ptr_q;
  assign almost_full = (occupancy >= (AW+1)'(AF_THRESH));
`endif

  router_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clock (clock),
    .we    (wr_go),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({lfd_state, data_in}),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_word)
  );

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pkt_cnt_d     = pkt_cnt_q;
    data_out_d    = data_out_q;
    pkt_rd_done_d = 1'b0;
    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pkt_cnt_d  = '0;
      data_out_d = '0;
    end else begin
      if (wr_go) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (rd_go) begin
        rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
        data_out_d = rd_word[WIDTH-1:0];
        // Header reload counts payload plus the trailing parity byte.
        if (rd_word[WIDTH]) begin
          pkt_cnt_d = CW'(rd_word[HDR_LEN_MSB:HDR_LEN_LSB]) + CW'(1);
        end else if (pkt_cnt_q != '0) begin
          pkt_cnt_d     = pkt_cnt_q - CW'(1);
          pkt_rd_done_d = (pkt_cnt_q == CW'(1));
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pkt_cnt_q     <= '0;
      data_out_q    <= '0;
      pkt_rd_done_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pkt_cnt_q     <= pkt_cnt_d;
      data_out_q    <= data_out_d;
      pkt_rd_done_q <= pkt_rd_done_d;
    end
  end

  assign data_out    = data_out_q;
  assign pkt_rd_done = pkt_rd_done_q;

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: queue-based reference model, directed and random stimulus.
module tb_router_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 14;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       full, empty, pkt_rd_done;
`ifdef ROUTER_FIFO_ALMOST_FULL_EN
  logic       almost_full;
`endif

  router_fifo #(
    .DEPTH     (DEPTH),
    .WIDTH     (8),
    .AF_THRESH (AF)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .soft_reset  (soft_reset),
    .write_enb   (write_enb),
    .read_enb    (read_enb),
    .lfd_state   (lfd_state),
    .data_in     (data_in),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
`ifdef ROUTER_FIFO_ALMOST_FULL_EN
    .almost_full (almost_full),
`endif
    .pkt_rd_done (pkt_rd_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] dout;
    logic       done;
    logic       full;
    logic       empty;
    logic       af;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] mq[$];
  logic [7:0] m_dout = '0;
  int         m_cnt = 0;
  logic       m_done = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: FIFO as a queue, packet length tracked as a plain remaining-bytes count.
  task automatic model(input bit we, input bit re, input bit lfd, input logic [7:0] din,
                       input bit srst);
    logic [8:0] e;
    bit rd_ok, wr_ok;
    if (srst) begin
      mq.delete();
      m_dout = '0;
      m_cnt  = 0;
      m_done = 1'b0;
    end else begin
      rd_ok  = re && (mq.size() > 0);
      wr_ok  = we && (mq.size() < DEPTH);
      m_done = 1'b0;
      if (rd_ok) begin
        e      = mq.pop_front();
        m_dout = e[7:0];
        if (e[8]) m_cnt = int'(e[7:2]) + 1;
        else if (m_cnt > 0) begin
          m_cnt--;
          m_done = (m_cnt == 0);
        end
      end
      if (wr_ok) mq.push_back({lfd, din});
    end
  endtask

  task automatic step(input bit we, input bit re, input bit lfd, input logic [7:0] din,
                      input bit srst);
    exp_t x;
    @(negedge clock);
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    soft_reset = srst;
    model(we, re, lfd, din, srst);
    x.dout  = m_dout;
    x.done  = m_done;
    x.full  = (mq.size() == DEPTH);
    x.empty = (mq.size() == 0);
    x.af    = (mq.size() >= AF);
    sb.push_back(x);
  endtask

  // Monitor: every clock that has an expectation queued, compare the registered/flag outputs.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("data_out", 32'(data_out), 32'(x.dout));
        chk("pkt_rd_done", 32'(pkt_rd_done), 32'(x.done));
        chk("full", 32'(full), 32'(x.full));
        chk("empty", 32'(empty), 32'(x.empty));
`ifdef ROUTER_FIFO_ALMOST_FULL_EN
        chk("almost_full", 32'(almost_full), 32'(x.af));
`endif
      end
    end
  end

  initial begin
    logic [7:0] pkt1 [5];
    pkt1[0] = 8'h0D; pkt1[1] = 8'h11; pkt1[2] = 8'h22; pkt1[3] = 8'h33; pkt1[4] = 8'h0D;

    #8;
    chk("reset_data_out", 32'(data_out), 32'h0);
    chk("reset_done", 32'(pkt_rd_done), 32'h0);
    chk("reset_full", 32'(full), 32'h0);
    chk("reset_empty", 32'(empty), 32'h1);
    #4 resetn = 1'b1;

    // Single packet, length 3: header, 3 payload, parity
    for (int i = 0; i < 5; i++) step(1, 0, i == 0, pkt1[i], 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00, 0);

    // Fill to full, dropped write of FF, read+write at full, read+write at one entry
    for (int i = 0; i < 16; i++)
      step(1, 0, i == 0, (i == 0) ? 8'h3C : 8'($urandom_range(0, 254)), 0);
    step(1, 0, 0, 8'hFF, 0);
    step(1, 1, 0, 8'hAA, 0);
    for (int i = 0; i < 14; i++) step(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 8'($urandom_range(0, 255)), 0);
    step(0, 1, 0, 8'h00, 0);
    step(0, 1, 0, 8'h00, 0);

    // Soft reset mid-packet, then a fresh length-1 packet
    step(1, 0, 1, 8'h14, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'($urandom_range(0, 255)), 0);
    step(0, 1, 0, 8'h00, 0);
    step(0, 1, 0, 8'h00, 0);
    step(1, 1, 0, 8'h5A, 1);
    step(1, 0, 1, 8'h04, 0);
    step(1, 0, 0, 8'h77, 0);
    step(1, 0, 0, 8'h04, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00, 0);

    // Almost-full threshold crossing
    for (int i = 0; i < 13; i++) step(1, 0, i == 0, 8'($urandom_range(0, 255)), 0);
    step(1, 0, 0, 8'h99, 0);
    step(0, 1, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 1);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 15, 8'($urandom_range(0, 255)),
           $urandom_range(0, 99) < 2);

    // Async reset between edges while holding 5 entries
    step(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) step(1, 0, i == 0, 8'($urandom_range(0, 255)), 0);
    step(0, 1, 0, 8'h00, 0);
    step(1, 0, 0, 8'h42, 0);
    @(posedge clock);
    #3;
    write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0; soft_reset = 1'b0;
    resetn = 1'b0;
    #1;
    chk("async_data_out", 32'(data_out), 32'h0);
    chk("async_done", 32'(pkt_rd_done), 32'h0);
    chk("async_full", 32'(full), 32'h0);
    chk("async_empty", 32'(empty), 32'h1);
`ifdef ROUTER_FIFO_ALMOST_FULL_EN
    chk("async_almost_full", 32'(almost_full), 32'h0);
`endif
    mq.delete();
    m_dout = '0;
    m_cnt  = 0;
    m_done = 1'b0;
    #2 resetn = 1'b1;

    // Post-reset: stale contents must not reappear; next header restarts the count
    step(0, 1, 0, 8'h00, 0);
    step(1, 0, 1, 8'h00, 0);
    step(1, 0, 0, 8'hE7, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 0);

    repeat (3) @(posedge clock);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
